// File: rtl/game_pkg.sv
// game_pkg: shared mode encoding and bus widths for the game sequencer
package game_pkg;
    localparam int GAMEMODE_W = 2;
    localparam int SCORE_W = 16;
    localparam int SPEED_W = 4;
    typedef enum logic [GAMEMODE_W-1:0] {
        MODE_MENU  = 2'b00,
        MODE_PLAY  = 2'b01,
        MODE_PAUSE = 2'b10,
        MODE_OVER  = 2'b11
    } mode_t;
endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: player inputs and mode/score outputs of the game sequencer
interface game_ctrl_if;
    import game_pkg::*;
    logic                  frame_tick;
    logic [2:0]            btn;
    logic                  collision;
    logic [GAMEMODE_W-1:0] gamemode;
    logic                  game_run;
    logic [SPEED_W-1:0]    scroll_speed;
    logic [SCORE_W-1:0]    score;
    logic [SCORE_W-1:0]    hi_score;
    logic                  new_record;
    logic                  sfx_start;
    logic                  sfx_over;
    modport master (
        input  frame_tick, btn, collision,
        output gamemode, game_run, scroll_speed, score, hi_score, new_record, sfx_start, sfx_over
    );
    modport slave (
        output frame_tick, btn, collision,
        input  gamemode, game_run, scroll_speed, score, hi_score, new_record, sfx_start, sfx_over
    );
endinterface

// File: rtl/btn_edge.sv
// btn_edge: rising-edge detector for debounced button levels
module btn_edge #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] btn,
    output logic [W-1:0] rise
);
    logic [W-1:0] btn_q;
    logic [W-1:0] armed;
    // button history; a bit is armed only once its button has been seen released,
    // so a button held through reset release never produces a rise
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            btn_q <= '0;
            armed <= '0;
        end else begin
            btn_q <= btn;
            armed <= armed | ~btn;
        end
    assign rise = btn & ~btn_q & armed;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game mode sequencer with score, high score and scroll-speed level
module game_ctrl
    import game_pkg::*;
#(
    parameter int SCORE_DIV  = 30,
    parameter int LEVEL_STEP = 10,
    parameter int SPEED_MIN  = 1,
    parameter int SPEED_MAX  = 8,
    parameter int OVER_HOLD  = 120
) (
    input  logic         clk,
    input  logic         rst_n,
    game_ctrl_if.master  bus
);
    localparam int FW = $clog2(SCORE_DIV);
    localparam int LW = $clog2(LEVEL_STEP);
    localparam int HW = $clog2(OVER_HOLD + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(SCORE_DIV - 1);
    localparam logic [LW-1:0] LEVEL_LAST = LW'(LEVEL_STEP - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(OVER_HOLD);
    localparam logic [SPEED_W-1:0] SPD_MIN = SPEED_W'(SPEED_MIN);
    localparam logic [SPEED_W-1:0] SPD_MAX = SPEED_W'(SPEED_MAX);
    mode_t               mode;
    logic [FW-1:0]       frame_cnt;
    logic [LW-1:0]       level_cnt;
    logic [HW-1:0]       hold_cnt;
    logic [SCORE_W-1:0]  score;
    logic [SCORE_W-1:0]  hi_score;
    logic [SPEED_W-1:0]  speed;
    logic                game_run;
    logic                new_record;
    logic                sfx_start;
    logic                sfx_over;
    logic [1:0]          rise;
    btn_edge #(.W(2)) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.btn[1:0]),
        .rise  (rise)
    );
    // mode FSM with scoring, level and over-screen hold; every output is a register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mode       <= MODE_MENU;
            frame_cnt  <= '0;
            level_cnt  <= '0;
            hold_cnt   <= '0;
            score      <= '0;
            hi_score   <= '0;
            speed      <= SPD_MIN;
            game_run   <= 1'b0;
            new_record <= 1'b0;
            sfx_start  <= 1'b0;
            sfx_over   <= 1'b0;
        end else begin
            new_record <= 1'b0;
            sfx_start  <= 1'b0;
            sfx_over   <= 1'b0;
            case (mode)
                MODE_MENU:
                    if (rise[0]) begin
                        mode      <= MODE_PLAY;
                        game_run  <= 1'b1;
                        score     <= '0;
                        frame_cnt <= '0;
                        level_cnt <= '0;
                        speed     <= SPD_MIN;
                        sfx_start <= 1'b1;
                    end
                MODE_PLAY:
                    if (bus.collision) begin
                        mode     <= MODE_OVER;
                        game_run <= 1'b0;
                        sfx_over <= 1'b1;
                        hold_cnt <= '0;
                        if (score > hi_score) begin
                            hi_score   <= score;
                            new_record <= 1'b1;
                        end
                    end else if (rise[1]) begin
                        mode     <= MODE_PAUSE;
                        game_run <= 1'b0;
                    end else if (bus.frame_tick) begin
                        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
                        if (frame_cnt == FRAME_LAST) begin
                            score     <= (score == '1) ? score : score + 1'b1;
                            level_cnt <= (level_cnt == LEVEL_LAST) ? '0 : level_cnt + 1'b1;
                            if (level_cnt == LEVEL_LAST && speed < SPD_MAX)
                                speed <= speed + 1'b1;
                        end
                    end
                MODE_PAUSE:
                    if (rise[1]) begin
                        mode     <= MODE_PLAY;
                        game_run <= 1'b1;
                    end else if (rise[0]) begin
                        mode <= MODE_MENU;
                    end
                MODE_OVER: begin
                    if (bus.frame_tick && hold_cnt != HOLD_MAX)
                        hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_MAX && rise[0])
                        mode <= MODE_MENU;
                end
            endcase
        end
    assign bus.gamemode     = mode;
    assign bus.game_run     = game_run;
    assign bus.scroll_speed = speed;
    assign bus.score        = score;
    assign bus.hi_score     = hi_score;
    assign bus.new_record   = new_record;
    assign bus.sfx_start    = sfx_start;
    assign bus.sfx_over     = sfx_over;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed and random stimulus against a behavioural game model
module tb_game_ctrl;
    localparam int SCORE_DIV  = 30;
    localparam int LEVEL_STEP = 10;
    localparam int SPEED_MIN  = 1;
    localparam int SPEED_MAX  = 8;
    localparam int OVER_HOLD  = 120;
    logic clk = 1'b0;
    logic rst_n;
    int total = 0;
    int bad = 0;
    game_ctrl_if bus();
    game_ctrl #(
        .SCORE_DIV(SCORE_DIV), .LEVEL_STEP(LEVEL_STEP), .SPEED_MIN(SPEED_MIN),
        .SPEED_MAX(SPEED_MAX), .OVER_HOLD(OVER_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    // reference model: a game is a count of scoring frame ticks, everything else derives from it
    int m_mode, m_ticks, m_hi, m_hold;
    bit m_rec, m_start, m_over;
    bit [2:0] m_pb, m_arm;
    function automatic int score_of(input int ticks);
        return (ticks / SCORE_DIV > 65535) ? 65535 : ticks / SCORE_DIV;
    endfunction
    function automatic int speed_of(input int ticks);
        int s;
        s = SPEED_MIN + score_of(ticks) / LEVEL_STEP;
        return (s > SPEED_MAX) ? SPEED_MAX : s;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_mode = 0; m_ticks = 0; m_hi = 0; m_hold = 0;
        m_rec = 0; m_start = 0; m_over = 0;
        m_pb = '0; m_arm = '0;
    endtask
    task automatic model_step(input bit t, input bit [2:0] b, input bit c);
        bit [2:0] r;
        int s;
        r = b & ~m_pb & m_arm;
        m_arm |= ~b;
        m_pb = b;
        m_rec = 0; m_start = 0; m_over = 0;
        s = score_of(m_ticks);
        case (m_mode)
            0: if (r[0]) begin m_mode = 1; m_ticks = 0; m_start = 1; end
            1: if (c) begin
                   m_mode = 3; m_over = 1; m_hold = 0;
                   if (s > m_hi) begin m_hi = s; m_rec = 1; end
               end else if (r[1]) m_mode = 2;
               else if (t) m_ticks++;
            2: if (r[1]) m_mode = 1; else if (r[0]) m_mode = 0;
            default: begin
                if (m_hold == OVER_HOLD && r[0]) m_mode = 0;
                if (t && m_hold < OVER_HOLD) m_hold++;
            end
        endcase
    endtask
    task automatic compare_all();
        chk("gamemode", 32'(bus.gamemode), m_mode);
        chk("game_run", 32'(bus.game_run), 32'(m_mode == 1));
        chk("scroll_speed", 32'(bus.scroll_speed), speed_of(m_ticks));
        chk("score", 32'(bus.score), score_of(m_ticks));
        chk("hi_score", 32'(bus.hi_score), m_hi);
        chk("new_record", 32'(bus.new_record), 32'(m_rec));
        chk("sfx_start", 32'(bus.sfx_start), 32'(m_start));
        chk("sfx_over", 32'(bus.sfx_over), 32'(m_over));
        chk("pulse_overlap", 32'(bus.sfx_start & (bus.sfx_over | bus.new_record)), 0);
    endtask
    task automatic step(input bit t, input bit [2:0] b, input bit c);
        @(negedge clk);
        bus.frame_tick = t;
        bus.btn = b;
        bus.collision = c;
        @(posedge clk);
        model_step(t, b, c);
        #1;
        compare_all();
    endtask
    task automatic ticks(input int n);
        repeat (n) begin
            step(1, 3'b000, 0);
            step(0, 3'b000, 0);
        end
    endtask
    task automatic do_reset(input bit [2:0] b);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.btn = b;
        bus.frame_tick = 1'b0;
        bus.collision = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
    initial begin
        bit [2:0] b;
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.btn = 3'b000;
        bus.collision = 1'b0;
        do_reset(3'b001);
        repeat (5) step(0, 3'b001, 0);
        chk("held_btn_menu", 32'(bus.gamemode), 0);
        step(0, 3'b000, 0);
        step(0, 3'b000, 0);
        step(0, 3'b001, 0);
        chk("start_mode", 32'(bus.gamemode), 1);
        chk("start_run", 32'(bus.game_run), 1);
        chk("start_sfx", 32'(bus.sfx_start), 1);
        chk("start_speed", 32'(bus.scroll_speed), 1);
        step(0, 3'b000, 0);
        chk("start_sfx_once", 32'(bus.sfx_start), 0);
        ticks(150);
        chk("score5", 32'(bus.score), 5);
        step(0, 3'b010, 1);
        chk("collide_over", 32'(bus.gamemode), 3);
        chk("collide_hi", 32'(bus.hi_score), 5);
        chk("collide_rec", 32'(bus.new_record), 1);
        chk("collide_sfx", 32'(bus.sfx_over), 1);
        step(0, 3'b000, 0);
        ticks(60);
        step(0, 3'b001, 0);
        chk("over_hold60", 32'(bus.gamemode), 3);
        step(0, 3'b000, 0);
        ticks(60);
        step(0, 3'b001, 0);
        chk("over_exit", 32'(bus.gamemode), 0);
        chk("hi_kept", 32'(bus.hi_score), 5);
        step(0, 3'b000, 0);
        step(0, 3'b001, 0);
        step(0, 3'b000, 0);
        ticks(90);
        chk("score3", 32'(bus.score), 3);
        step(0, 3'b010, 0);
        chk("paused", 32'(bus.gamemode), 2);
        step(0, 3'b000, 0);
        ticks(100);
        chk("pause_frozen", 32'(bus.score), 3);
        step(0, 3'b010, 0);
        chk("resumed", 32'(bus.gamemode), 1);
        step(0, 3'b000, 0);
        step(0, 3'b000, 1);
        chk("no_record", 32'(bus.new_record), 0);
        chk("hi_still5", 32'(bus.hi_score), 5);
        step(0, 3'b000, 0);
        ticks(OVER_HOLD);
        step(0, 3'b001, 0);
        step(0, 3'b000, 0);
        step(0, 3'b001, 0);
        step(0, 3'b000, 0);
        ticks(300);
        chk("score10", 32'(bus.score), 10);
        chk("speed2", 32'(bus.scroll_speed), 2);
        ticks(2700);
        chk("score100", 32'(bus.score), 100);
        chk("speed_clamp", 32'(bus.scroll_speed), 8);
        do_reset(3'b000);
        chk("async_rst_mode", 32'(bus.gamemode), 0);
        chk("async_rst_score", 32'(bus.score), 0);
        b = 3'b000;
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 3; k++)
                if ($urandom_range(7) == 0) b[k] = ~b[k];
            step($urandom_range(2) == 0, b, $urandom_range(39) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
